// File: rtl/velocity_update_ctrl.sv
// Per-cell velocity memory sequencer: streams particle velocities to the motion-update
// unit and writes the returned values back, sharing one memory port (write-back wins).
module velocity_update_ctrl #(
    parameter int DATA_WIDTH   = 96,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_rden,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic [DATA_WIDTH-1:0] out_velocity,
    output logic [ADDR_WIDTH-1:0] out_id,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic [DATA_WIDTH-1:0] in_velocity,
    input  logic [ADDR_WIDTH-1:0] in_id,
    input  logic                  in_valid
);

    typedef enum logic [2:0] {
        IDLE,
        CNT_RD,
        CNT_WAIT,
        RUN,
        DRAIN,
        FINISH
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] N_MAX = ADDR_WIDTH'(PARTICLE_NUM - 1);

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] n_count;
    logic [ADDR_WIDTH-1:0] n_capture;
    logic [ADDR_WIDTH-1:0] cnt_raw;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] wr_cnt;
    logic [ADDR_WIDTH-1:0] wr_cnt_next;
    logic                  rd_pending;
    logic                  rd_fire;
    logic                  wb_fire;
    logic                  out_consume;

    // The stored count can exceed the memory depth; clamp it so reads stay in range.
    assign cnt_raw     = mem_q[ADDR_WIDTH-1:0];
    assign n_capture   = (cnt_raw > N_MAX) ? N_MAX : cnt_raw;
    assign out_consume = out_valid && out_ready;
    assign wb_fire     = in_valid && ((state == RUN) || (state == DRAIN));
    assign rd_fire     = (state == RUN) && (rd_ptr <= n_count) && !rd_pending &&
                         !in_valid && (!out_valid || out_consume);
    assign wr_cnt_next = wr_cnt + ADDR_WIDTH'(wb_fire);

    always_comb begin
        state_next  = state;
        mem_address = '0;
        mem_data    = '0;
        mem_rden    = 1'b0;
        mem_wren    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = CNT_RD;
            end
            CNT_RD: begin
                mem_rden   = 1'b1;
                state_next = CNT_WAIT;
            end
            CNT_WAIT: begin
                state_next = (n_capture == '0) ? FINISH : RUN;
            end
            RUN: begin
                if ((rd_ptr > n_count) && !rd_pending && !out_valid) state_next = DRAIN;
            end
            DRAIN: begin
                if (wr_cnt_next == n_count) state_next = FINISH;
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (wb_fire) begin
            mem_address = in_id;
            mem_data    = in_velocity;
            mem_wren    = 1'b1;
        end else if (rd_fire) begin
            mem_address = rd_ptr;
            mem_rden    = 1'b1;
        end
    end

    // Single outstanding read: the pending flag marks the cycle mem_q carries particle data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            n_count      <= '0;
            rd_ptr       <= '0;
            rd_addr      <= '0;
            wr_cnt       <= '0;
            rd_pending   <= 1'b0;
            out_velocity <= '0;
            out_id       <= '0;
            out_valid    <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE) && (state_next != FINISH);
            done  <= (state_next == FINISH);
            if (state == CNT_WAIT) begin
                n_count <= n_capture;
                rd_ptr  <= ADDR_WIDTH'(1);
                wr_cnt  <= '0;
            end else begin
                if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
                wr_cnt <= wr_cnt_next;
            end
            rd_pending <= rd_fire;
            if (rd_fire) rd_addr <= rd_ptr;
            if (out_consume) out_valid <= 1'b0;
            if (rd_pending) begin
                out_velocity <= mem_q;
                out_id       <= rd_addr;
                out_valid    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_velocity_update_ctrl.sv
// Directed bench for velocity_update_ctrl with a behavioural single-port memory
// and an optional update-unit model that returns data+1 two cycles after each transfer.
module tb_velocity_update_ctrl;

    localparam int DW = 96;
    localparam int AW = 8;
    localparam int PN = 220;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data;
    logic          mem_rden;
    logic          mem_wren;
    logic [DW-1:0] mem_q;
    logic [DW-1:0] out_velocity;
    logic [AW-1:0] out_id;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] in_velocity;
    logic [AW-1:0] in_id;
    logic          in_valid;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [DW-1:0] mem [0:255];
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;

    int rden_cnt = 0;
    int wren_cnt = 0;
    int ov_cnt   = 0;
    int done_cnt = 0;
    int both_cnt = 0;
    logic [AW-1:0] xfer_q [$];

    logic          unit_on;
    logic          p0_v;
    logic [AW-1:0] p0_id;
    logic [DW-1:0] p0_d;

    velocity_update_ctrl #(
        .DATA_WIDTH  (DW),
        .PARTICLE_NUM(PN),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_rden    (mem_rden),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q),
        .out_velocity(out_velocity),
        .out_id      (out_id),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .in_velocity (in_velocity),
        .in_id       (in_id),
        .in_valid    (in_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (mem_wren) mem[mem_address] <= mem_data;
        if (mem_rden) mem_q <= mem[mem_address];
    end

    // Activity monitor sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (mem_rden) rden_cnt <= rden_cnt + 1;
        if (mem_wren) wren_cnt <= wren_cnt + 1;
        if (mem_rden && mem_wren) both_cnt <= both_cnt + 1;
        if (out_valid) ov_cnt <= ov_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (out_valid && out_ready) xfer_q.push_back(out_id);
    end

    function automatic logic [DW-1:0] pword(input int k);
        return {32'hC0DE_0000, 32'h0000_BEEF, 32'(k)};
    endfunction

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus();
        logic          xfer;
        logic [AW-1:0] xid;
        logic [DW-1:0] xdat;
        xfer = unit_on && out_valid && out_ready;
        xid  = out_id;
        xdat = out_velocity;
        @(posedge clk);
        #1;
        cyc++;
        start = 1'b0;
        if (unit_on) begin
            in_valid    = p0_v;
            in_id       = p0_id;
            in_velocity = p0_d + 96'd1;
            p0_v        = xfer;
            p0_id       = xid;
            p0_d        = xdat;
        end
    endtask

    task automatic loadWord(input int addr, input logic [DW-1:0] data);
        ld_en   = 1'b1;
        ld_addr = AW'(addr);
        ld_data = data;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput(tag, done, 1'b1);
    endtask

    task automatic waitValid(input string tag, input int budget);
        int n = 0;
        while (out_valid !== 1'b1 && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput(tag, out_valid, 1'b1);
    endtask

    task automatic unitOff();
        unit_on  = 1'b0;
        p0_v     = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        int base_a;
        int base_b;
        int q_base;
        int first_valid;
        int bad;
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        in_valid = 1'b0; in_id = '0; in_velocity = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        unit_on = 1'b0; p0_v = 1'b0; p0_id = '0; p0_d = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_rden", mem_rden, 1'b0);
        checkOutput("rst_wren", mem_wren, 1'b0);
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_addr", mem_address, 0);
        checkOutput("rst_mem_data", mem_data, 0);
        checkOutput("rst_out_velocity", out_velocity, 0);
        checkOutput("rst_out_id", out_id, 0);
        rst = 1'b0;

        // N = 0: minimum pass.
        loadWord(0, 96'd0);
        base_a = wren_cnt; base_b = ov_cnt;
        start = 1'b1; cyc = 0;
        applyStimulus();
        checkOutput("n0_busy_c1", busy, 1'b1);
        checkOutput("n0_cnt_rden_c1", mem_rden, 1'b1);
        checkOutput("n0_cnt_addr_c1", mem_address, 0);
        applyStimulus();
        checkOutput("n0_busy_c2", busy, 1'b1);
        applyStimulus();
        checkOutput("n0_done_c3", done, 1'b1);
        checkOutput("n0_busy_c3", busy, 1'b0);
        applyStimulus();
        checkOutput("n0_done_c4", done, 1'b0);
        checkOutput("n0_no_wren", wren_cnt - base_a, 0);
        checkOutput("n0_no_out_valid", ov_cnt - base_b, 0);

        // N = 3 with the update-unit model.
        loadWord(0, 96'd3);
        for (int k = 1; k <= 3; k++) loadWord(k, pword(k));
        unitOff();
        unit_on = 1'b1; out_ready = 1'b1;
        q_base = xfer_q.size(); base_a = done_cnt;
        first_valid = -1;
        start = 1'b1; cyc = 0;
        while (done !== 1'b1 && cyc < 60) begin
            applyStimulus();
            if (out_valid === 1'b1 && first_valid < 0) first_valid = cyc;
        end
        checkOutput("n3_first_valid_cycle", first_valid, 5);
        checkOutput("n3_done_cycle", cyc, 13);
        applyStimulus();
        applyStimulus();
        checkOutput("n3_done_pulses", done_cnt - base_a, 1);
        checkOutput("n3_xfer_count", xfer_q.size() - q_base, 3);
        for (int k = 1; k <= 3; k++) begin
            checkOutput("n3_out_id_seq", xfer_q[q_base + k - 1], k);
            checkOutput("n3_mem_updated", mem[k], pword(k + 1));
        end
        unitOff();

        // Back-pressure: N = 4, out_ready low for 10 cycles after the first valid.
        loadWord(0, 96'd4);
        for (int k = 1; k <= 4; k++) loadWord(k, pword(16 + k));
        unit_on = 1'b1; out_ready = 1'b0;
        q_base = xfer_q.size();
        start = 1'b1; cyc = 0;
        waitValid("bp_first_valid", 20);
        base_a = rden_cnt;
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_hold_id", out_id, 1);
            checkOutput("bp_hold_velocity", out_velocity, pword(17));
            applyStimulus();
        end
        checkOutput("bp_no_rden_while_stalled", rden_cnt - base_a, 0);
        out_ready = 1'b1;
        waitDone("bp_done", 80);
        checkOutput("bp_xfer_count", xfer_q.size() - q_base, 4);
        for (int k = 1; k <= 4; k++) checkOutput("bp_out_id_seq", xfer_q[q_base + k - 1], k);
        applyStimulus();
        checkOutput("bp_mem4_updated", mem[4], pword(21));
        unitOff();

        // Collision: write-back of id 2 in the cycle the read of address 3 would issue.
        loadWord(0, 96'd3);
        for (int k = 1; k <= 3; k++) loadWord(k, pword(32 + k));
        out_ready = 1'b1;
        start = 1'b1; cyc = 0;
        repeat (7) applyStimulus();
        in_valid = 1'b1; in_id = 8'd2; in_velocity = 96'hDEAD_0000_0000_0000_0000_0002;
        #1;
        checkOutput("col_wren", mem_wren, 1'b1);
        checkOutput("col_rden_blocked", mem_rden, 1'b0);
        checkOutput("col_wr_addr", mem_address, 2);
        checkOutput("col_wr_data", mem_data, 96'hDEAD_0000_0000_0000_0000_0002);
        applyStimulus();
        in_valid = 1'b0;
        #1;
        checkOutput("col_retry_rden", mem_rden, 1'b1);
        checkOutput("col_retry_addr", mem_address, 3);
        waitValid("col_valid3", 10);
        checkOutput("col_out_id3", out_id, 3);
        applyStimulus();
        in_valid = 1'b1; in_id = 8'd1; in_velocity = pword(101);
        applyStimulus();
        in_id = 8'd3; in_velocity = pword(103);
        applyStimulus();
        in_valid = 1'b0;
        waitDone("col_done", 10);
        applyStimulus();
        checkOutput("col_mem2", mem[2], 96'hDEAD_0000_0000_0000_0000_0002);

        // Saturation: count word 0xFF clamps to PARTICLE_NUM-1.
        loadWord(0, 96'hFF);
        unitOff();
        unit_on = 1'b1; out_ready = 1'b1;
        q_base = xfer_q.size();
        start = 1'b1; cyc = 0;
        waitDone("sat_done", 1500);
        checkOutput("sat_xfer_count", xfer_q.size() - q_base, 219);
        checkOutput("sat_last_id", xfer_q[xfer_q.size() - 1], 219);
        bad = 0;
        for (int i = 0; i < xfer_q.size() - q_base; i++)
            if (xfer_q[q_base + i] !== AW'(i + 1)) bad++;
        checkOutput("sat_order", bad, 0);
        applyStimulus();
        unitOff();

        // Mid-pass reset, plus start while busy.
        loadWord(0, 96'd3);
        for (int k = 1; k <= 3; k++) loadWord(k, pword(48 + k));
        out_ready = 1'b0;
        start = 1'b1; cyc = 0;
        repeat (3) applyStimulus();
        start = 1'b1;
        applyStimulus();
        checkOutput("busy_start_ignored_rden", mem_rden, 1'b0);
        checkOutput("busy_start_ignored_busy", busy, 1'b1);
        applyStimulus();
        checkOutput("mr_valid_c5", out_valid, 1'b1);
        checkOutput("mr_id_c5", out_id, 1);
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        checkOutput("mr_out_valid_cleared", out_valid, 1'b0);
        checkOutput("mr_busy_cleared", busy, 1'b0);
        applyStimulus();
        checkOutput("mr_idle_no_rden", mem_rden, 1'b0);
        checkOutput("mr_idle_busy", busy, 1'b0);
        start = 1'b1; cyc = 0;
        applyStimulus();
        checkOutput("mr_restart_rden", mem_rden, 1'b1);
        checkOutput("mr_restart_addr", mem_address, 0);
        repeat (4) applyStimulus();
        checkOutput("mr_restart_valid_c5", out_valid, 1'b1);
        checkOutput("mr_restart_id_c5", out_id, 1);
        unit_on = 1'b1; out_ready = 1'b1;
        waitDone("mr_done", 60);
        applyStimulus();
        unitOff();

        checkOutput("no_read_write_overlap", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/velocity_update_ctrl.md
# velocity_update_ctrl

Sequencer that owns the single port of one per-cell velocity memory during the motion-update phase. On `start` it reads the particle count from address 0 and streams each particle velocity (addresses 1..N) to the downstream motion-update unit over a valid/ready handshake. It writes the updated velocities returned by that unit back into the same memory. Write-back has priority over reads on the shared port. One instance sits between each velocity cell memory and the motion-update pipeline.

## Interface
- `DATA_WIDTH`, 96: velocity word, `{vz, vy, vx}`, 32 bits each.
- `PARTICLE_NUM`, 220: memory depth in words (address 0 plus particles).
- `ADDR_WIDTH`, 8: memory address width.

- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin an update pass. Ignored unless the controller is in IDLE.
- `busy`  out  1  high from the cycle after an accepted `start` until the cycle `done` is asserted.
- `done`  out  1  one-cycle pulse when the pass is complete.
- `mem_address`  out  ADDR_WIDTH  memory address.
- `mem_data`  out  DATA_WIDTH  memory write data.
- `mem_rden`  out  1  memory read enable.
- `mem_wren`  out  1  memory write enable.
- `mem_q`  in  DATA_WIDTH  memory read data, valid 1 cycle after `mem_rden`.
- `out_velocity`  out  DATA_WIDTH  velocity sent to the update unit.
- `out_id`  out  ADDR_WIDTH  address of that particle.
- `out_valid`  out  1  `out_velocity`/`out_id` are valid.
- `out_ready`  in  1  the update unit accepts the word; a transfer happens when `out_valid && out_ready`.
- `in_velocity`  in  DATA_WIDTH  updated velocity.
- `in_id`  in  ADDR_WIDTH  write-back address.
- `in_valid`  in  1  write-back request; always accepted, there is no back-pressure.

## Operation
- **States:** IDLE, CNT_RD, CNT_WAIT, RUN, DRAIN, FINISH.
- **IDLE:**
  - `start` moves to CNT_RD.
  - All memory enables are 0.
- **CNT_RD:** drive `mem_address`=0 with `mem_rden`=1, then go to CNT_WAIT.
- **CNT_WAIT:**
  - Capture `N = mem_q[ADDR_WIDTH-1:0]`, saturated to PARTICLE_NUM-1.
  - Set `rd_ptr`=1 and `wr_cnt`=0.
  - If N=0, go to FINISH; otherwise go to RUN.
- **Read issue** (RUN only) happens when all of the following hold:
  - `rd_ptr` ≤ N
  - no read is pending
  - `in_valid`=0
  - the output register is empty, or is being consumed this cycle
- **On read issue:**
  - `mem_address`=`rd_ptr`, `mem_rden`=1.
  - Set the pending flag and increment `rd_ptr`.
- **Read return** (cycle after issue):
  - Load `out_velocity`←`mem_q` and `out_id`←issued address.
  - `out_valid` becomes 1 on the following edge.
  - Clear the pending flag.
- `out_valid` holds, with stable data, until `out_ready`.
- **Write-back** (RUN or DRAIN):
  - When `in_valid`=1, drive `mem_address`=`in_id`, `mem_data`=`in_velocity`, `mem_wren`=1, `mem_rden`=0.
  - Increment `wr_cnt`.
  - In the same cycle the read issue is suppressed and retried on the next cycle.
- `in_valid` in IDLE, CNT_RD, CNT_WAIT or FINISH is ignored: no write, no count.
- `in_id` of 0 or greater than N is still written. Avoiding this is the update unit's responsibility.
- RUN goes to DRAIN once `rd_ptr` > N, no read is pending, and `out_valid`=0.
- DRAIN goes to FINISH once `wr_cnt`=N.
  - A write arriving in that same cycle is counted first, so `wr_cnt` reaching N on the edge qualifies.
- **FINISH:** `done`=1 for one cycle, `busy`=0, then go to IDLE.
- `rst` in any state:
  - Returns to IDLE.
  - Clears the pending flag, `rd_ptr` and `wr_cnt`.
  - Drops any in-flight read data.
  - Memory contents are not touched.

## Timing
- **Reset values:** `busy`, `done`, `mem_rden`, `mem_wren`, `out_valid` = 0; `mem_address`, `mem_data`, `out_velocity`, `out_id` = 0.
- Memory outputs are combinational from state/registers. `out_*`, `busy` and `done` are registered.
- `start` at cycle 0:
  - `busy`=1 at cycle 1.
  - Count read issued at cycle 1, captured at cycle 2.
  - First particle read issued at cycle 3.
  - `out_valid`=1 at cycle 5, with `out_id`=1.
- Read throughput is one read per 2 cycles when there are no stalls (single outstanding read).
- A memory read and write never occur in the same cycle.
- `done` fires the cycle after the last write-back is counted.
- Minimum pass (N=0): `start` at cycle 0, `done` at cycle 3.

## Test plan
- **N=0 pass:** memory word 0 = 0, pulse `start`.
  - Required: `done` at cycle 3.
  - Required: no `out_valid`, no `mem_wren`.
- **N=3 pass:** particle words 0x…01/02/03, `out_ready`=1, update unit returns data+1 two cycles after each transfer.
  - Required: `out_id` sequence 1,2,3.
  - Required: memory holds 0x…02/03/04 afterwards.
  - Required: `done` pulses once.
- **Back-pressure:** N=4, `out_ready`=0 for 10 cycles after the first `out_valid`.
  - Required: `out_velocity`/`out_id`=1 held stable.
  - Required: no further `mem_rden` until the transfer.
  - Required: all 4 ids are eventually delivered in order.
- **Collision:** assert `in_valid` (`in_id`=2) in exactly the cycle a read of address 3 would issue.
  - Required: write occurs with `mem_rden`=0.
  - Required: read of 3 is issued on the next cycle.
  - Required: `out_id`=3 is delivered.
- **Saturation:** memory word 0 = 0xFF with PARTICLE_NUM=220.
  - Required: N=219.
  - Required: last `out_id`=219.
- **Mid-pass reset:** `rst` during RUN with `out_valid`=1.
  - Required: next cycle `out_valid`=0, `busy`=0, state IDLE.
  - Required: a new `start` restarts from address 0.
  - Required: `start` pulsed while `busy`=1 has no effect.
